// File: rtl/tty_uart_tx.sv
// ---------------------------------------------------------------------------
// tty_uart_tx
// Buffers characters written by the MCU's TTY port in a small FIFO and sends
// them out as asynchronous UART frames (start, DATA_W data bits LSB first,
// optional even parity, STOP_BITS stop bits) on a single line that idles high.
//
// Build option: define TTY_UART_PARITY_EN to add an even-parity bit between
// the data bits and the stop bits.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_in      asynchronous active-low reset
//   data_i      character to transmit
//   we_i        write strobe, one character per high cycle
//   clr_ovf_i   clears the sticky overflow flag
//   full_o      FIFO full (registered)
//   empty_o     FIFO empty (registered)
//   level_o     FIFO occupancy (registered)
//   overflow_o  sticky flag: a write was dropped because the FIFO was full
//   busy_o      serialiser is not idle (registered)
//   tx_o        UART line (registered, high when idle)
// ---------------------------------------------------------------------------
module tty_uart_tx #(
    parameter int DATA_W     = 7,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 434,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_in,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        we_i,
    input  logic                        clr_ovf_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        overflow_o,
    output logic                        busy_o,
    output logic                        tx_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef TTY_UART_PARITY_EN
    function automatic logic f_even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_ovf;
    logic [LW-1:0]     w_level_nxt;
    logic              w_push;
    logic              w_pop;

    // Serialiser
    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_tick;
    logic [TW-1:0]     w_tick_nxt;
    logic [BW-1:0]     r_bit_cnt;
    logic [BW-1:0]     w_bit_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_busy;
    logic              w_bit_end;
`ifdef TTY_UART_PARITY_EN
    logic              r_par;
    logic              w_par_nxt;
`endif

    // Full is the registered flag, so a write while full is refused even if
    // the serialiser pops in the same cycle.
    assign w_push    = we_i & ~r_full;
    assign w_pop     = (r_state == S_IDLE) & ~r_empty;
    assign w_bit_end = (r_tick == TW'(CLK_DIV - 1));

    // Occupancy update: simultaneous push and pop leave the level unchanged
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1'b1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1'b1);
        end else begin
            w_level_nxt = r_level;
        end
    end

    // FIFO data array write port (contents need no reset)
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // FIFO pointers, level/flags and sticky overflow
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == {LW{1'b0}});
            r_full  <= (w_level_nxt == LW'(FIFO_DEPTH));
            // A drop in the same cycle as a clear keeps the flag set
            if (we_i && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Serialiser next-state, bit timer, bit counter and line value
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = w_bit_end ? {TW{1'b0}} : (r_tick + TW'(1'b1));
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
`ifdef TTY_UART_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_tick_nxt = {TW{1'b0}};
                w_bit_nxt  = {BW{1'b0}};
                if (!r_empty) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = r_mem[r_rd_ptr];
`ifdef TTY_UART_PARITY_EN
                    w_par_nxt   = f_even_parity(r_mem[r_rd_ptr]);
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = {BW{1'b0}};
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
                    if (r_bit_cnt == BW'(DATA_W - 1)) begin
`ifdef TTY_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                        w_bit_nxt   = {BW{1'b0}};
                    end else begin
                        w_bit_nxt   = r_bit_cnt + BW'(1'b1);
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef TTY_UART_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = {BW{1'b0}};
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == BW'(STOP_BITS - 1)) begin
                        w_state_nxt = S_IDLE;
                        w_bit_nxt   = {BW{1'b0}};
                    end else begin
                        w_bit_nxt   = r_bit_cnt + BW'(1'b1);
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = {TW{1'b0}};
                w_bit_nxt   = {BW{1'b0}};
            end
        endcase

        // Line value follows the current state; it is registered below
        case (r_state)
            S_IDLE:   w_tx_nxt = 1'b1;
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[0];
`ifdef TTY_UART_PARITY_EN
            S_PARITY: w_tx_nxt = r_par;
`endif
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Serialiser state register and registered line/busy outputs
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state   <= S_IDLE;
            r_tick    <= {TW{1'b0}};
            r_bit_cnt <= {BW{1'b0}};
            r_shift   <= {DATA_W{1'b0}};
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef TTY_UART_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= (r_state != S_IDLE);
`ifdef TTY_UART_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    assign full_o     = r_full;
    assign empty_o    = r_empty;
    assign level_o    = r_level;
    assign overflow_o = r_ovf;
    assign busy_o     = r_busy;
    assign tx_o       = r_tx;

endmodule

// File: tb/tb_tty_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_tty_uart_tx
// Self-checking bench for tty_uart_tx. A queue-based reference model tracks
// the FIFO contents, the overflow flag and the expected line waveform; every
// cycle the DUT outputs are compared against it. Directed scenarios pin the
// model with hand-computed values; a second instance with two stop bits and a
// longer bit period is checked with literal run lengths.
// ---------------------------------------------------------------------------
module tb_tty_uart_tx;

    localparam int DW    = 7;
    localparam int DEPTH = 4;
    localparam int CD    = 4;
    localparam int SB    = 1;
    localparam int LW    = 3;
`ifdef TTY_UART_PARITY_EN
    localparam int PB    = 1;
`else
    localparam int PB    = 0;
`endif

    logic          clk       = 1'b0;
    logic          rst_in    = 1'b1;
    logic [DW-1:0] data_i    = 7'h00;
    logic          we_i      = 1'b0;
    logic          clr_ovf_i = 1'b0;
    logic          full_o, empty_o, overflow_o, busy_o, tx_o;
    logic [LW-1:0] level_o;

    logic [DW-1:0] d2  = 7'h00;
    logic          we2 = 1'b0;
    logic          full2, empty2, ovf2, busy2, tx2;
    logic [2:0]    level2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tty_uart_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CD), .STOP_BITS(SB)) dut (
        .clk_i(clk), .rst_in(rst_in), .data_i(data_i), .we_i(we_i),
        .clr_ovf_i(clr_ovf_i), .full_o(full_o), .empty_o(empty_o),
        .level_o(level_o), .overflow_o(overflow_o), .busy_o(busy_o), .tx_o(tx_o)
    );

    tty_uart_tx #(.DATA_W(DW), .FIFO_DEPTH(4), .CLK_DIV(8), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .rst_in(rst_in), .data_i(d2), .we_i(we2),
        .clr_ovf_i(1'b0), .full_o(full2), .empty_o(empty2),
        .level_o(level2), .overflow_o(ovf2), .busy_o(busy2), .tx_o(tx2)
    );

    // Clock generator
    always #5 clk = ~clk;

    // Edge counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_fifo[$];
    logic          m_bits[$];
    logic          m_tx    = 1'b1;
    logic          m_busy  = 1'b0;
    logic          m_empty = 1'b1;
    logic          m_full  = 1'b0;
    logic          m_ovf   = 1'b0;
    int            m_level = 0;
    logic          m_idle, m_was_full;

    // Appends the per-cycle line values of one whole frame
    function automatic void build_frame(input logic [DW-1:0] d);
        for (int c = 0; c < CD; c++) m_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++)
            for (int c = 0; c < CD; c++) m_bits.push_back(d[i]);
`ifdef TTY_UART_PARITY_EN
        for (int c = 0; c < CD; c++) m_bits.push_back(^d);
`endif
        for (int c = 0; c < SB * CD; c++) m_bits.push_back(1'b1);
    endfunction

    // Model update: one step per clock, cleared by reset at any time
    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            m_fifo.delete();
            m_bits.delete();
            m_tx = 1'b1; m_busy = 1'b0; m_empty = 1'b1; m_full = 1'b0;
            m_ovf = 1'b0; m_level = 0;
        end else begin
            m_idle     = (m_bits.size() == 0);
            m_was_full = (m_fifo.size() == DEPTH);
            if (!m_idle) begin
                m_tx   = m_bits.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
            if (m_idle && m_fifo.size() != 0) build_frame(m_fifo.pop_front());
            if (we_i && !m_was_full) m_fifo.push_back(data_i);
            if (we_i && m_was_full) m_ovf = 1'b1;
            else if (clr_ovf_i) m_ovf = 1'b0;
            m_level = m_fifo.size();
            m_empty = (m_level == 0);
            m_full  = (m_level == DEPTH);
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        check("tx", int'(tx_o), int'(m_tx));
        check("busy", int'(busy_o), int'(m_busy));
        check("level", int'(level_o), m_level);
        check("empty", int'(empty_o), int'(m_empty));
        check("full", int'(full_o), int'(m_full));
        check("overflow", int'(overflow_o), int'(m_ovf));
    end

    // ---------------- helpers ----------------
    task automatic rx_frame(output logic [DW-1:0] d, output logic p,
                            output int nbusy, output int fall);
        logic s[64];
        logic b[64];
        for (int k = 0; k < 300; k++) begin
            if (tx_o == 1'b0) break;
            @(negedge clk);
        end
        check("rx_start_seen", int'(tx_o), 0);
        fall  = cyc;
        nbusy = 0;
        for (int k = 0; k < 64; k++) begin
            s[k] = tx_o;
            b[k] = busy_o;
            @(negedge clk);
        end
        for (int j = 0; j < DW; j++) d[j] = s[CD * (1 + j)];
        p = s[CD * (1 + DW)];
        for (int k = 0; k < 64; k++) if (b[k]) nbusy++;
    endtask

    task automatic wait_idle(input string nm);
        int stable = 0;
        for (int k = 0; k < 3000; k++) begin
            if (empty_o && !busy_o) stable++;
            else stable = 0;
            if (stable == 3) break;
            @(negedge clk);
        end
        check(nm, stable, 3);
    endtask

    task automatic run_len2(input logic lvl, output int n);
        n = 0;
        while (tx2 == lvl && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] rd;
        logic          rp;
        int            nb, fl, n, a, b, c, lows;

        #1 rst_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx", int'(tx_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_empty", int'(empty_o), 1);
        check("rst_full", int'(full_o), 0);
        check("rst_level", int'(level_o), 0);
        check("rst_ovf", int'(overflow_o), 0);
        rst_in = 1'b1;
        repeat (3) @(negedge clk);

        // Single character 0x41
        data_i = 7'h41; we_i = 1'b1;
        @(negedge clk);
        n = cyc; we_i = 1'b0;
        rx_frame(rd, rp, nb, fl);
        check("t1_fall_latency", fl, n + 2);
        check("t1_data", int'(rd), 'h41);
        check("t1_busy_cycles", nb, 36 + PB * CD);
`ifdef TTY_UART_PARITY_EN
        check("t6_parity_41", int'(rp), 0);
`endif
        check("t1_level", int'(level_o), 0);
        check("t1_ovf", int'(overflow_o), 0);

`ifdef TTY_UART_PARITY_EN
        data_i = 7'h43; we_i = 1'b1;
        @(negedge clk);
        we_i = 1'b0;
        rx_frame(rd, rp, nb, fl);
        check("t6_data_43", int'(rd), 'h43);
        check("t6_parity_43", int'(rp), 1);
        check("t6_frame_cycles", nb, 40);
`endif
        wait_idle("t1_idle");

        // Overflow: six back-to-back writes
        for (int i = 1; i <= 6; i++) begin
            data_i = DW'(i); we_i = 1'b1;
            @(negedge clk);
        end
        we_i = 1'b0;
        check("t2_full", int'(full_o), 1);
        check("t2_level", int'(level_o), 4);
        check("t2_ovf", int'(overflow_o), 1);

        // Overflow clear alone, then clear together with a dropped write
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;
        check("t3_clr", int'(overflow_o), 0);
        clr_ovf_i = 1'b1; we_i = 1'b1; data_i = 7'h07;
        @(negedge clk);
        clr_ovf_i = 1'b0; we_i = 1'b0;
        check("t3_set_wins", int'(overflow_o), 1);
        wait_idle("t2_drain");
        clr_ovf_i = 1'b1;
        @(negedge clk);
        clr_ovf_i = 1'b0;

        // Reset mid-frame during data bit 3 of 0x55 with two entries queued
        data_i = 7'h55; we_i = 1'b1; @(negedge clk);
        data_i = 7'h11;              @(negedge clk);
        data_i = 7'h22;              @(negedge clk);
        we_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (tx_o == 1'b0) break;
            @(negedge clk);
        end
        repeat (CD * 4 + 1) @(negedge clk);
        check("t4_bit3_low", int'(tx_o), 0);
        check("t4_queued", int'(level_o), 2);
        #1 rst_in = 1'b0;
        #1;
        check("t4_tx_async", int'(tx_o), 1);
        check("t4_level", int'(level_o), 0);
        check("t4_empty", int'(empty_o), 1);
        check("t4_busy", int'(busy_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b1;
        lows = 0;
        for (int k = 0; k < 100; k++) begin
            if (tx_o == 1'b0) lows++;
            @(negedge clk);
        end
        check("t4_no_residual", lows, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            we_i      = ($urandom_range(0, 9) == 0);
            data_i    = DW'($urandom_range(0, 127));
            clr_ovf_i = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        we_i = 1'b0; clr_ovf_i = 1'b0;
        wait_idle("rand_drain");

        // Two stop bits, eight cycles per bit: 0x7F then 0x00
        d2 = 7'h7F; we2 = 1'b1; @(negedge clk);
        d2 = 7'h00;             @(negedge clk);
        we2 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (tx2 == 1'b0) break;
            @(negedge clk);
        end
        run_len2(1'b0, a);
        run_len2(1'b1, b);
        run_len2(1'b0, c);
        check("t5_start_len", a, 8);
        check("t5_high_run", b, 73 + PB * 8);
        check("t5_second_low", c, 64 + PB * 8);
        for (int k = 0; k < 300; k++) begin
            if (!busy2 && empty2) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("t5_busy_end", int'(busy2), 0);
        check("t5_empty_end", int'(empty2), 1);
        check("t5_level_end", int'(level2), 0);
        check("t5_full_end", int'(full2), 0);
        check("t5_ovf_end", int'(ovf2), 0);
        check("t5_line_idle", int'(tx2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tty_uart_tx.md
Name: tty_uart_tx

Overview:
Parametrised successor to the MCU's bare 7-bit TTY write port (data plus write strobe). It buffers TTY writes in a FIFO and serialises them as asynchronous UART frames on a single pin, so console output leaves the FPGA without a host-side VCD probe. Data width, FIFO depth, bit period and stop-bit count are configurable. It sits between the MCU's tty_o/tty_we_o outputs and the board TX pin.

Parameters:
DATA_W, 7, character width in bits; 5..8.
FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.
CLK_DIV, 434, clk_i cycles per UART bit; at least 2.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk_i  in  1  system clock; all logic on the rising edge.
rst_in  in  1  asynchronous active-low reset.
data_i  in  DATA_W  character to transmit (from MCU tty_o).
we_i  in  1  write strobe; one character per high cycle.
clr_ovf_i  in  1  clears sticky overflow flag.
full_o  out  1  FIFO full (registered).
empty_o  out  1  FIFO empty (registered).
level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow_o  out  1  sticky: a write was dropped.
busy_o  out  1  serialiser not in IDLE.
tx_o  out  1  UART line; idles high.

Behaviour:
- Reset (rst_in=0, asynchronous): tx_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0, overflow_o=0, FSM=IDLE, pointers=0, bit counters=0. Reset mid-frame aborts the frame and discards FIFO contents. tx_o returns high without waiting for a clock.
- Write: accepted if and only if we_i=1 and the registered full_o=0. The write is not accepted when full, even if a pop occurs in the same cycle. The rejected character is dropped and overflow_o is set on the next edge.
- overflow_o: cleared only by clr_ovf_i=1. If a drop and clr_ovf_i occur in the same cycle, set wins.
- level_o: +1 on push only, -1 on pop only, unchanged on push and pop together. empty_o = (level==0) and full_o = (level==FIFO_DEPTH), both registered with level_o. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. A bit timer counts 0..CLK_DIV-1 and each state bit lasts exactly CLK_DIV cycles.
  - IDLE: tx_o=1. If empty_o=0, pop the head into the shift register and go to START.
  - START: tx_o=0.
  - DATA: DATA_W bits, LSB first.
  - STOP: tx_o=1 for STOP_BITS*CLK_DIV cycles, then return to IDLE.
- Latency: a write at edge N into an empty FIFO with the FSM in IDLE gives a pop at edge N+1. tx_o falls after edge N+2 (start bit begins).
- Back-to-back frames: the FSM passes through IDLE for exactly 1 cycle between frames. The inter-frame gap is therefore STOP_BITS*CLK_DIV+1 cycles of high line.
- busy_o = (state != IDLE), registered.
- Frame length excluding the IDLE cycle: (1 + DATA_W + STOP_BITS)*CLK_DIV cycles.

Optional Feature:
Macro TTY_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits an even-parity bit (XOR of the DATA_W data bits) for CLK_DIV cycles, and frame length grows by CLK_DIV.
- Not defined: no PARITY state; frames are start + data + stop only.

Test Plan:
Default config for all scenarios unless noted: DATA_W=7, FIFO_DEPTH=4, CLK_DIV=4, STOP_BITS=1, macro off.
1. Single character: release reset, write 0x41 at edge N -> tx_o low for edges N+2..N+5, then bits 1,0,0,0,0,0,1 at 4 cycles each, then high 4 cycles. busy_o high 36 cycles. level_o returns to 0, overflow_o stays 0.
2. Overflow: 6 back-to-back writes 0x01..0x06 from idle -> 0x01 popped, 0x02..0x05 stored, full_o=1, 0x06 dropped, overflow_o=1. Line carries 0x01..0x05 in order, each frame separated by a 5-cycle high gap.
3. Overflow clear: with overflow_o=1, pulse clr_ovf_i alone -> 0 next edge. Pulse clr_ovf_i together with a write while full -> overflow_o stays 1.
4. Reset mid-frame: deassert rst_in during the DATA bit 3 of 0x55 with 2 entries queued -> tx_o=1 immediately, level_o=0, empty_o=1. After release the line stays idle with no residual frames.
5. STOP_BITS=2, CLK_DIV=8: write 0x7F then 0x00 -> stop high 16 cycles. The second start bit falls 17 cycles after the first frame's stop begins.
6. TTY_UART_PARITY_EN defined: write 0x41 -> parity bit 0. Write 0x43 -> parity bit 1. Each frame is 40 cycles before IDLE.
